demux_deser_16: RTL and testbench

- Receiving end of the 16-to-1 mux serial link. A 16:1 mux driven by a counting select (s3..s0 = 0..15) puts one channel per cycle onto a single wire. This block de-multiplexes that serial stream back into 16 parallel channels.
- It tracks the channel index with an internal select counter, assembles a full 16-bit frame, and hands it out on a valid/ready interface.
- It supports frame realignment through `sync` and flags overrun.

---
 rtl/demux_deser_16.sv | 121 ++++++++++++
 tb/tb_demux_deser_16.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/demux_deser_16.sv
// Serial-to-parallel receiver for the 16:1 mux link: rebuilds N-bit frames from a
// one-bit-per-cycle stream and presents them on a valid/ready port with overrun tracking.
module demux_deser_16 #(
  parameter int N         = 16,
  parameter int SEL_W     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  input  logic             word_ready,
  input  logic             clear_ovr,
  output logic [SEL_W-1:0] sel_out,
  output logic [N-1:0]     word_out,
  output logic             word_valid,
  output logic             overrun
);

  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N-1);

  // Channel index to the assembly bit it occupies for the configured bit order.
  function automatic logic [SEL_W-1:0] bit_pos(input logic [SEL_W-1:0] sel);
    if (LSB_FIRST != 0) begin
      return sel;
    end else begin
      return SEL_LAST - sel;
    end
  endfunction

  logic [SEL_W-1:0] sel_r, sel_nxt_s;
  logic [N-1:0]     asm_r, asm_nxt_s;
  logic [N-1:0]     word_r, word_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic [N-1:0]     with_bit_s, sync_word_s, frame_s;
  logic             done_s, load_s, drop_s, xfer_s;

  // Assembly path: counter advance, frame restart and frame completion detection.
  always_comb begin
    with_bit_s                          = asm_r;
    with_bit_s[bit_pos(sel_r)]          = din;
    sync_word_s                         = {N{1'b0}};
    sync_word_s[bit_pos(SEL_ZERO)]      = din;
    asm_nxt_s                           = asm_r;
    sel_nxt_s                           = sel_r;
    frame_s                             = with_bit_s;
    done_s                              = 1'b0;
    if (sync) begin
      if (din_valid) begin
        asm_nxt_s = sync_word_s;
        sel_nxt_s = SEL_ONE;
      end else begin
        asm_nxt_s = {N{1'b0}};
        sel_nxt_s = SEL_ZERO;
      end
    end else if (din_valid) begin
      if (sel_r == SEL_LAST) begin
        done_s    = 1'b1;
        asm_nxt_s = {N{1'b0}};
        sel_nxt_s = SEL_ZERO;
      end else begin
        asm_nxt_s = with_bit_s;
        sel_nxt_s = sel_r + SEL_ONE;
      end
    end else begin
      asm_nxt_s = asm_r;
      sel_nxt_s = sel_r;
    end
  end

  // Output handshake: a finished frame loads if the holding register is free or draining.
  always_comb begin
    xfer_s = valid_r & word_ready;
    load_s = done_s & (~valid_r | word_ready);
    drop_s = done_s & valid_r & ~word_ready;
    if (load_s) begin
      word_nxt_s  = frame_s;
      valid_nxt_s = 1'b1;
    end else if (xfer_s) begin
      word_nxt_s  = word_r;
      valid_nxt_s = 1'b0;
    end else begin
      word_nxt_s  = word_r;
      valid_nxt_s = valid_r;
    end
    if (drop_s) begin
      ovr_nxt_s = 1'b1;
    end else if (clear_ovr) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= SEL_ZERO;
      asm_r   <= {N{1'b0}};
      word_r  <= {N{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      sel_r   <= sel_nxt_s;
      asm_r   <= asm_nxt_s;
      word_r  <= word_nxt_s;
      valid_r <= valid_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

  assign sel_out    = sel_r;
  assign word_out   = word_r;
  assign word_valid = valid_r;
  assign overrun    = ovr_r;

endmodule

// File: tb/tb_demux_deser_16.sv
// Scoreboard bench for demux_deser_16: expected frames are queued as bits are sent
// and popped when the receiver presents them.
module tb_demux_deser_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        sync = 1'b0;
  logic        word_ready = 1'b0;
  logic        clear_ovr = 1'b0;
  logic [3:0]  sel_out, sel_out_m;
  logic [15:0] word_out, word_out_m;
  logic        word_valid, word_valid_m;
  logic        overrun, overrun_m;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  logic [15:0] exp_w;

  demux_deser_16 #(.N(16), .SEL_W(4), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .word_ready(word_ready), .clear_ovr(clear_ovr), .sel_out(sel_out),
    .word_out(word_out), .word_valid(word_valid), .overrun(overrun)
  );

  demux_deser_16 #(.N(16), .SEL_W(4), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .word_ready(word_ready), .clear_ovr(clear_ovr), .sel_out(sel_out_m),
    .word_out(word_out_m), .word_valid(word_valid_m), .overrun(overrun_m)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = v[i];
    return r;
  endfunction

  task automatic cycle(input logic d, input logic v, input logic s);
    din = d; din_valid = v; sync = s;
    @(posedge clk); #1;
    din = 1'b0; din_valid = 1'b0; sync = 1'b0;
  endtask

  // stream[k] is the k-th serial bit
  task automatic send_bits(input logic [15:0] stream, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) cycle(stream[k], 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (sel_out !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel_out); end
    checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL reset_word got %h want 0000", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", word_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
  endtask

  task automatic test_bit_order;
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < 16; k++) s[k] = (k % 4 != 0);
    word_ready = 1'b1;
    q.push_back(s);
    send_bits(s, 0, 15);
    exp_w = q.pop_front();
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", word_valid); end
    checks++; if (word_out !== exp_w) begin errors++; $display("FAIL lsb_word got %h want %h", word_out, exp_w); end
    checks++; if (word_out !== 16'hEEEE) begin errors++; $display("FAIL lsb_const got %h want EEEE", word_out); end
    checks++; if (sel_out !== 4'd0) begin errors++; $display("FAIL lsb_sel got %0d want 0", sel_out); end
    checks++; if (word_out_m !== rev16(s)) begin errors++; $display("FAIL msb_word got %h want %h", word_out_m, rev16(s)); end
    checks++; if (word_out_m !== 16'h7777) begin errors++; $display("FAIL msb_const got %h want 7777", word_out_m); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL lsb_drain got %b want 0", word_valid); end
  endtask

  task automatic test_sync;
    word_ready = 1'b1;
    send_bits(16'h00FF, 0, 4);
    checks++; if (sel_out !== 4'd5) begin errors++; $display("FAIL sync_pre_sel got %0d want 5", sel_out); end
    cycle(1'b1, 1'b0, 1'b1);
    checks++; if (sel_out !== 4'd0) begin errors++; $display("FAIL sync_idle_sel got %0d want 0", sel_out); end
    send_bits(16'h00FF, 0, 2);
    q.push_back(16'h0001);
    cycle(1'b1, 1'b1, 1'b1);
    checks++; if (sel_out !== 4'd1) begin errors++; $display("FAIL sync_sel got %0d want 1", sel_out); end
    send_bits(16'h0000, 1, 14);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_early got %b want 0", word_valid); end
    send_bits(16'h0000, 15, 15);
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL sync_word got %h/%b want %h/1", word_out, word_valid, exp_w); end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_once got %b want 0", word_valid); end
  endtask

  task automatic test_overrun;
    word_ready = 1'b0;
    q.push_back(16'h1234);
    send_bits(16'h1234, 0, 15);
    send_bits(16'hABCD, 0, 15);
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got %h/%b want %h/1", word_out, word_valid, exp_w); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    word_ready = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    word_ready = 1'b0;
    checks++; if (word_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_xfer got %b/%b want 0/1", word_valid, overrun); end
    clear_ovr = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    clear_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
    q.push_back(16'h5A5A);
    send_bits(16'h5A5A, 0, 15);
    send_bits(16'h0F0F, 0, 14);
    clear_ovr = 1'b1;
    send_bits(16'h0F0F, 15, 15);
    clear_ovr = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_setwins got %b want 1", overrun); end
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w) begin errors++; $display("FAIL ovr_keep got %h want %h", word_out, exp_w); end
    word_ready = 1'b1; clear_ovr = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    word_ready = 1'b0; clear_ovr = 1'b0;
  endtask

  task automatic test_back_to_back;
    word_ready = 1'b0;
    q.push_back(16'hC3A5);
    send_bits(16'hC3A5, 0, 15);
    q.push_back(16'h96E1);
    send_bits(16'h96E1, 0, 14);
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL b2b_old got %h/%b want %h/1", word_out, word_valid, exp_w); end
    word_ready = 1'b1;
    send_bits(16'h96E1, 15, 15);
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL b2b_new got %h/%b want %h/1", word_out, word_valid, exp_w); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b want 0", overrun); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", word_valid); end
  endtask

  task automatic test_gapped;
    logic [15:0] s;
    s = 16'hEEEE;
    word_ready = 1'b1;
    q.push_back(s);
    for (int k = 0; k < 16; k++) begin
      cycle(s[k], 1'b1, 1'b0);
      if (k < 15) begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (k == 6) begin
          checks++; if (sel_out !== 4'd7) begin errors++; $display("FAIL gap_sel got %0d want 7", sel_out); end
        end
      end
    end
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL gap_word got %h/%b want %h/1", word_out, word_valid, exp_w); end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    word_ready = 1'b0;
    send_bits(16'hFFFF, 0, 15);
    send_bits(16'hFFFF, 0, 15);
    send_bits(16'hFFFF, 0, 6);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (word_out !== 16'h0000 || word_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_word got %h/%b want 0000/0", word_out, word_valid); end
    checks++; if (sel_out !== 4'd0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_sel got %0d/%b want 0/0", sel_out, overrun); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b1;
    q.push_back(16'h8421);
    send_bits(16'h8421, 0, 15);
    exp_w = q.pop_front();
    checks++; if (word_out !== exp_w || word_valid !== 1'b1) begin errors++; $display("FAIL rst_after got %h/%b want %h/1", word_out, word_valid, exp_w); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL sb_empty got %0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_sync();
    test_overrun();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
